// File: rtl/ram_sp_dist.sv
// ram_sp_dist: parametrised single-port distributed RAM with asynchronous or registered read.
// Define RAM_SP_DIST_CLEAR_EN to build the clear sequencer (BUSY/WERR/CLR); otherwise words load INIT_WORD at time zero.
module ram_sp_dist #(
  parameter int                DATA_W    = 4,
  parameter int                ADDR_W    = 4,
  parameter int                READ_REG  = 0,
  parameter logic [DATA_W-1:0] INIT_WORD = '0
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              WRE,
  input  logic [ADDR_W-1:0] AD,
  input  logic [DATA_W-1:0] DI,
  input  logic              CLR,
  output logic [DATA_W-1:0] DO,
  output logic              BUSY,
  output logic              WERR
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              busy;
  logic              wr_en;
  logic [DATA_W-1:0] rd_word;

`ifdef RAM_SP_DIST_CLEAR_EN
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              werr_q, werr_d;
  logic              clr_we;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      werr_q  <= werr_d;
    end
  end

  // CLR is only looked at in IDLE, so a request during a sweep never restarts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (CLR) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_comb begin
    busy   = (state_q == ST_CLEAR);
    clr_we = busy;
    wr_en  = WRE & ~busy;
    werr_d = WRE & busy;
  end

  always @(posedge CLK) begin
    if (clr_we) begin
      mem[cnt_q] <= INIT_WORD;
    end else if (wr_en) begin
      mem[AD] <= DI;
    end
  end

  assign WERR = werr_q;
`else
  logic unused_ok;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = INIT_WORD;
    end
  end

  assign busy  = 1'b0;
  assign wr_en = WRE;
  assign WERR  = 1'b0;
  // CLR has no function here; RESETN only matters when the read port is registered.
  assign unused_ok = ^{CLR, RESETN};

  always @(posedge CLK) begin
    if (wr_en) begin
      mem[AD] <= DI;
    end
  end
`endif

  assign BUSY    = busy;
  assign rd_word = busy ? '0 : mem[AD];

  // Registered read samples mem before this edge's write lands (read-first).
  generate
    if (READ_REG != 0) begin : g_rd_reg
      logic [DATA_W-1:0] do_q;
      always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
          do_q <= '0;
        end else begin
          do_q <= rd_word;
        end
      end
      assign DO = do_q;
    end else begin : g_rd_async
      assign DO = rd_word;
    end
  endgenerate

endmodule

// File: doc/ram_sp_dist.md
# ram_sp_dist

Parametrised single-port distributed RAM: the generalised successor to the fixed 16x4 shadow-SRAM primitive model. Width and depth are configurable, and the read port is either asynchronous or registered. An optional clear sequencer fills every word with a constant after reset or on request. It sits beside the other Gowin primitive models and is used for register files, small lookup tables and scratch buffers in Verilator builds.

## Interface
- DATA_W, 4: word width in bits, 1..64.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W, range 2..10.
- READ_REG, 0: 0 = asynchronous read; 1 = registered read with one-cycle latency.
- INIT_WORD, 0: DATA_W-bit value loaded into every word, either at time zero or by the clear sequencer.
- CLK  in  1  clock; all state changes on the rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- WRE  in  1  write enable.
- AD  in  ADDR_W  shared read/write address.
- DI  in  DATA_W  write data.
- CLR  in  1  clear request, sampled on the rising edge.
- DO  out  DATA_W  read data.
- BUSY  out  1  clear sequence in progress.
- WERR  out  1  one-cycle pulse: a write was dropped because BUSY was high.

## Operation
- Writes:
  - On a rising edge with WRE=1 and BUSY=0, mem[AD] <= DI.
  - With BUSY=1 the write is dropped and WERR=1 on the next cycle.
- READ_REG=0:
  - DO = mem[AD] combinationally.
  - DO = 0 while BUSY=1.
  - A write is visible on DO immediately after the edge.
- READ_REG=1:
  - Each edge with BUSY=0 loads DO <= mem[AD] using pre-write contents (read-first).
  - Each edge with BUSY=1 loads DO <= 0.
- Clear sequencer FSM, with states IDLE and CLEAR and a counter CNT of ADDR_W bits:
  - Reset forces CLEAR with CNT=0.
  - In CLEAR, each edge writes mem[CNT] <= INIT_WORD and increments CNT.
  - At CNT = DEPTH-1 the FSM writes the last word and goes to IDLE.
  - In IDLE, CLR=1 forces CLEAR with CNT=0 on the next edge.
  - CLR while in CLEAR is ignored; the sweep does not restart.
  - BUSY=1 exactly while in CLEAR.
- Reset values:
  - BUSY=1, WERR=0, CNT=0.
  - Registered DO=0; asynchronous DO reads 0 because BUSY=1.
  - Memory contents are not reset; the sequencer overwrites them.
- Reset asserted mid-clear aborts the sweep. The sweep restarts at address 0 when RESETN rises; words already written keep INIT_WORD.
- WRE=1 together with CLR=1 in IDLE: the write completes and the clear starts on the same edge, so that word is overwritten later in the sweep.

## Timing
- Clear duration is DEPTH cycles. After RESETN rises, BUSY stays high for edges 1..DEPTH and falls after edge DEPTH.
- The first accepted write is at edge DEPTH+1.
- Read latency:
  - READ_REG=0: 0 cycles.
  - READ_REG=1: 1 cycle; the AD sampled at edge n is presented on DO after edge n.
- WERR is high for exactly one cycle per dropped write, on the cycle after the edge that dropped it.
- CLR pulse accepted at edge n: BUSY=1 from edge n through edge n+DEPTH-1.

## Configuration
- RAM_SP_DIST_CLEAR_EN defined: the clear sequencer, BUSY, WERR and CLR are active as described above.
- RAM_SP_DIST_CLEAR_EN undefined:
  - No FSM or counter is built.
  - An initial block loads INIT_WORD into every word at time zero.
  - BUSY and WERR are tied to 0; CLR is ignored.
  - RESETN clears only the registered DO.
  - Writes are accepted from the first edge after reset.

## Test plan
- Reset release, DATA_W=8, ADDR_W=4, INIT_WORD=8'hA5, clear enabled -> BUSY high for 16 edges. Reading all 16 addresses afterwards returns 8'hA5.
- WRE=1 at edge 3 after reset with AD=2, DI=8'h3C -> WERR pulses for one cycle. mem[2] reads 8'hA5 after the clear.
- READ_REG=1: write 8'h11 to address 5, then at the next edge write 8'h22 to address 5 with AD=5 -> DO=8'h11 after the second edge and 8'h22 after the third.
- READ_REG=0: write 8'h7E to address 15 -> DO=8'h7E in the same cycle after the edge. CLR pulse -> DO=0 for 16 cycles, then 8'hA5.
- RESETN dropped at clear edge 8 and released 3 cycles later -> BUSY stays high, CNT restarts at 0, and BUSY falls 16 edges after release.
- Macro undefined, ADDR_W=2, INIT_WORD=8'h5A -> words read 8'h5A at time zero. CLR has no effect, BUSY=0, and a write on the first edge after reset is accepted.
